// File: rtl/uart_apb_slave_pkg.sv
// rtl/uart_apb_slave_pkg.sv - register map, FSM encoding and address constants for the UART APB completer
//
// Purpose : definitions used by the APB completer and the register bank.
// Contents: word indices of the UART registers, FSM state type,
//           the low-address field layout used by the legality check.

package uart_apb_slave_pkg;

    // Word index (paddr[4:2]) of each register in the bank.
    localparam logic [2:0] REG_CONTROL = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_DIVISOR = 3'd2;
    localparam logic [2:0] REG_TXDATA  = 3'd3;
    localparam logic [2:0] REG_RXDATA  = 3'd4;

    // Address bits [4:0] are the only ones that may be nonzero, and of those
    // only the word-index bits [4:2].
    localparam int unsigned ADDR_FIELD_W  = 5;
    localparam logic [4:0]  ADDR_IDX_MASK = 5'b1_1100;

    localparam logic [3:0] STRB_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ACC   = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_ERR_ACC  = 3'd4
    } apb_state_e;

endpackage

// File: rtl/uart_apb_decode.sv
// rtl/uart_apb_decode.sv - combinational legality check of an APB setup phase
//
// Purpose: decides whether a transfer may reach the register bank and
//          extracts the word index.
// Ports  : paddr_i  - byte address
//          pwrite_i - 1 = write
//          pstrb_i  - write byte strobes
//          legal_o  - transfer is legal
//          index_o  - word index paddr_i[4:2]

module uart_apb_decode
    import uart_apb_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic [3:0]        pstrb_i,
    output logic              legal_o,
    output logic [2:0]        index_o
);

    logic upper_zero;
    logic aligned;
    logic in_map;
    logic dir_ok;
    logic strb_ok;

    always_comb begin
        index_o    = paddr_i[4:2];
        upper_zero = (paddr_i[ADDR_W-1:ADDR_FIELD_W] == '0);
        aligned    = ((paddr_i[ADDR_FIELD_W-1:0] & ~ADDR_IDX_MASK) == 5'b0);
        in_map     = (index_o <= REG_RXDATA);

        // TXDATA is write-only, RXDATA is read-only.
        if (pwrite_i) begin
            dir_ok = (index_o != REG_RXDATA);
        end else begin
            dir_ok = (index_o != REG_TXDATA);
        end

        // TXDATA only needs its low byte; the full-width registers must be
        // written whole so the bank never sees a partial update.
        strb_ok = 1'b1;
        if (pwrite_i) begin
            if (index_o == REG_TXDATA) begin
                strb_ok = pstrb_i[0];
            end else begin
                strb_ok = (pstrb_i == STRB_ALL);
            end
        end

        legal_o = upper_zero & aligned & in_map & dir_ok & strb_ok;
    end

endmodule

// File: rtl/uart_apb_slave.sv
// rtl/uart_apb_slave.sv - APB3 completer issuing single-cycle strobes to the UART register bank
//
// Purpose: turns each accepted APB transfer into exactly one ctrl_wr_o or
//          ctrl_rd_o strobe; illegal accesses complete with pslverr_o.
// Ports  : clk_i, rst_n_i (async active-low)
//          psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i - APB request
//          prdata_o, pready_o, pslverr_o                          - APB response
//          ctrl_wr_o, ctrl_rd_o, ctrl_addr_o, ctrl_data_o          - bank request
//          ctrl_rdata_i - bank read data, valid one cycle after ctrl_rd_o

module uart_apb_slave
    import uart_apb_slave_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [3:0]        pstrb_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic              ctrl_wr_o,
    output logic              ctrl_rd_o,
    output logic [2:0]        ctrl_addr_o,
    output logic [DATA_W-1:0] ctrl_data_o,
    input  logic [DATA_W-1:0] ctrl_rdata_i
);

    apb_state_e        state_q, state_d;
    logic [2:0]        ctrl_addr_q, ctrl_addr_d;
    logic [DATA_W-1:0] ctrl_data_q, ctrl_data_d;

    logic       setup;
    logic       legal;
    logic [2:0] index;

    assign setup = psel_i & ~penable_i;

    uart_apb_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .paddr_i  (paddr_i),
        .pwrite_i (pwrite_i),
        .pstrb_i  (pstrb_i),
        .legal_o  (legal),
        .index_o  (index)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ctrl_addr_q <= '0;
            ctrl_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_data_q <= ctrl_data_d;
        end
    end

    // Next state. A stray access phase in IDLE (penable without setup) is not
    // a setup, so it never starts a transfer.
    always_comb begin
        state_d     = state_q;
        ctrl_addr_d = ctrl_addr_q;
        ctrl_data_d = ctrl_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    ctrl_addr_d = index;
                    ctrl_data_d = pwdata_i;
                    if (!legal) begin
                        state_d = ST_ERR_ACC;
                    end else if (pwrite_i) begin
                        state_d = ST_WR_ACC;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            // The read strobe is already out this cycle; an abort only skips
            // the data phase, so no second strobe can follow.
            ST_RD_ISSUE: state_d = psel_i ? ST_RD_DATA : ST_IDLE;
            ST_WR_ACC,
            ST_RD_DATA,
            ST_ERR_ACC:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so an asynchronous reset clears them
    // immediately and strobes last exactly one cycle.
    always_comb begin
        ctrl_wr_o   = 1'b0;
        ctrl_rd_o   = 1'b0;
        pready_o    = 1'b0;
        pslverr_o   = 1'b0;
        prdata_o    = '0;
        ctrl_addr_o = ctrl_addr_q;
        ctrl_data_o = ctrl_data_q;
        unique case (state_q)
            ST_WR_ACC: begin
                ctrl_wr_o = 1'b1;
                pready_o  = 1'b1;
            end
            ST_RD_ISSUE: begin
                ctrl_rd_o = 1'b1;
            end
            ST_RD_DATA: begin
                pready_o = 1'b1;
                prdata_o = ctrl_rdata_i;
            end
            ST_ERR_ACC: begin
                pready_o  = 1'b1;
                pslverr_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_uart_apb_slave.sv
// tb/tb_uart_apb_slave.sv - directed self-checking bench for uart_apb_slave

module tb_uart_apb_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        ctrl_wr;
    logic        ctrl_rd;
    logic [2:0]  ctrl_addr;
    logic [31:0] ctrl_data;
    logic [31:0] bank_rdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_apb_slave #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pstrb_i      (pstrb),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .ctrl_wr_o    (ctrl_wr),
        .ctrl_rd_o    (ctrl_rd),
        .ctrl_addr_o  (ctrl_addr),
        .ctrl_data_o  (ctrl_data),
        .ctrl_rdata_i (bank_rdata)
    );

    // Register bank model: registered read data, RX pops on each read of index 4.
    logic [31:0] m_ctrl = 32'h0;
    logic [31:0] m_div  = 32'h10;
    logic [31:0] rx_fifo [4] = '{32'hA5, 32'h5A, 32'h3C, 32'hC3};
    int          rx_rd = 0;

    always @(posedge clk) begin
        if (ctrl_rd) begin
            case (ctrl_addr)
                3'd0: bank_rdata <= m_ctrl;
                3'd1: bank_rdata <= 32'h11;
                3'd2: bank_rdata <= m_div;
                3'd4: begin
                    bank_rdata <= rx_fifo[rx_rd % 4];
                    rx_rd      <= rx_rd + 1;
                end
                default: bank_rdata <= 32'h0;
            endcase
        end
        if (ctrl_wr) begin
            case (ctrl_addr)
                3'd0: m_ctrl <= ctrl_data;
                3'd2: m_div  <= ctrl_data;
                default: ;
            endcase
        end
    end

    // Strobe log, sampled mid-cycle.
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overlap = 0;
    int          log_n = 0;
    int          log_kind [32];
    logic [2:0]  log_addr [32];
    logic [31:0] log_data [32];

    always @(negedge clk) begin
        if (ctrl_wr && ctrl_rd) overlap++;
        if (ctrl_wr) begin
            wr_cnt++;
            if (log_n < 32) begin
                log_kind[log_n] = 1;
                log_addr[log_n] = ctrl_addr;
                log_data[log_n] = ctrl_data;
                log_n++;
            end
        end
        if (ctrl_rd) begin
            rd_cnt++;
            if (log_n < 32) begin
                log_kind[log_n] = 2;
                log_addr[log_n] = ctrl_addr;
                log_data[log_n] = ctrl_data;
                log_n++;
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd, output logic err,
                            output int waits, output logic tout);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; tout = 1'b1; rd = '0; err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pready) begin
                rd = prdata; err = pslverr; tout = 1'b0;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({pready, pslverr, ctrl_wr, ctrl_rd, prdata, ctrl_addr, ctrl_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b err=%b wr=%b rd=%b prdata=%h addr=%h data=%h want all 0",
                     pready, pslverr, ctrl_wr, ctrl_rd, prdata, ctrl_addr, ctrl_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        logic [31:0] rd; logic err; int waits; logic tout; int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        apb_xfer(1'b1, 12'h008, 32'h0000_001A, 4'hF, rd, err, waits, tout);
        apb_idle();
        n_cmp++;
        if (tout !== 1'b0 || waits != 0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp: got tout=%b waits=%0d err=%b want 0/0/0", tout, waits, err);
        end
        n_cmp++;
        if (wr_cnt != w0 + 1 || rd_cnt != r0) begin
            n_fail++;
            $display("FAIL write_strobes: got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_cnt - w0, rd_cnt - r0, 1, 0);
        end
        n_cmp++;
        if (log_addr[log_n-1] !== 3'd2 || log_data[log_n-1] !== 32'h1A) begin
            n_fail++;
            $display("FAIL write_addr_data: got addr=%0d data=%h want addr=2 data=0000001a",
                     log_addr[log_n-1], log_data[log_n-1]);
        end
    endtask

    task automatic test_read_rx();
        logic [31:0] rd; logic err; int waits; logic tout; int r0, p0;
        r0 = rd_cnt; p0 = rx_rd;
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, err, waits, tout);
        apb_idle();
        n_cmp++;
        if (tout !== 1'b0 || waits != 1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp: got tout=%b waits=%0d err=%b want 0/1/0", tout, waits, err);
        end
        n_cmp++;
        if (rd !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL read_data: got %h want 000000a5", rd);
        end
        n_cmp++;
        if (rd_cnt != r0 + 1 || rx_rd != p0 + 1) begin
            n_fail++;
            $display("FAIL read_single_pop: got strobes=%0d pops=%0d want 1/1", rd_cnt - r0, rx_rd - p0);
        end
    endtask

    task automatic test_illegal();
        logic        t_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [11:0] t_addr [4] = '{12'h00C, 12'h010, 12'h01C, 12'h002};
        logic [31:0] rd; logic err; int waits; logic tout; int n0;
        for (int i = 0; i < 4; i++) begin
            n0 = log_n;
            apb_xfer(t_wr[i], t_addr[i], 32'hDEAD_BEEF, 4'hF, rd, err, waits, tout);
            apb_idle();
            n_cmp++;
            if (tout !== 1'b0 || waits != 0 || err !== 1'b1 || rd !== 32'h0 || log_n != n0) begin
                n_fail++;
                $display("FAIL illegal_%0d: got tout=%b waits=%0d err=%b rdata=%h strobes=%0d want 0/0/1/0/0",
                         i, tout, waits, err, rd, log_n - n0);
            end
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int waits; logic tout; int n0;
        n0 = log_n;
        apb_xfer(1'b1, 12'h000, 32'h1234_5678, 4'h3, rd, err, waits, tout);
        apb_idle();
        n_cmp++;
        if (tout !== 1'b0 || err !== 1'b1 || log_n != n0) begin
            n_fail++;
            $display("FAIL partial_ctrl_write: got tout=%b err=%b strobes=%0d want 0/1/0", tout, err, log_n - n0);
        end
        n0 = log_n;
        apb_xfer(1'b1, 12'h00C, 32'h0000_0055, 4'h1, rd, err, waits, tout);
        apb_idle();
        n_cmp++;
        if (tout !== 1'b0 || err !== 1'b0 || log_n != n0 + 1) begin
            n_fail++;
            $display("FAIL tx_byte_write: got tout=%b err=%b strobes=%0d want 0/0/1", tout, err, log_n - n0);
        end else begin
            n_cmp++;
            if (log_kind[n0] != 1 || log_addr[n0] !== 3'd3 || log_data[n0] !== 32'h55) begin
                n_fail++;
                $display("FAIL tx_byte_strobe: got kind=%0d addr=%0d data=%h want 1/3/00000055",
                         log_kind[n0], log_addr[n0], log_data[n0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd0, rd1; logic e0, e1; int w0, w1; logic t0, t1; int n0;
        n0 = log_n;
        apb_xfer(1'b1, 12'h00C, 32'h0000_0077, 4'hF, rd0, e0, w0, t0);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, rd1, e1, w1, t1);
        apb_idle();
        n_cmp++;
        if (t0 || t1 || e0 || e1 || w0 != 0 || w1 != 1 || rd1 !== 32'h11) begin
            n_fail++;
            $display("FAIL b2b_resp: got tout=%b%b err=%b%b waits=%0d/%0d rdata=%h want 00 00 0/1 00000011",
                     t0, t1, e0, e1, w0, w1, rd1);
        end
        n_cmp++;
        if (log_n != n0 + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d strobes want 2", log_n - n0);
        end else begin
            n_cmp++;
            if (log_kind[n0] != 1 || log_addr[n0] !== 3'd3 || log_kind[n0+1] != 2 || log_addr[n0+1] !== 3'd1) begin
                n_fail++;
                $display("FAIL b2b_order: got %0d@%0d,%0d@%0d want 1@3,2@1",
                         log_kind[n0], log_addr[n0], log_kind[n0+1], log_addr[n0+1]);
            end
        end
    endtask

    task automatic test_stray_penable();
        int n0;
        n0 = log_n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h99; pstrb = 4'hF;
        @(posedge clk); #1;
        n_cmp++;
        if (pready !== 1'b0 || ctrl_wr !== 1'b0 || ctrl_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_penable_outputs: got rdy=%b wr=%b rd=%b want 0/0/0", pready, ctrl_wr, ctrl_rd);
        end
        apb_idle();
        apb_idle();
        n_cmp++;
        if (log_n != n0) begin
            n_fail++;
            $display("FAIL stray_penable_strobe: got %0d strobes want 0", log_n - n0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd; logic err; int waits; logic tout;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (pready !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_rd_data: got pready=%b want 1", pready);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pready, pslverr, ctrl_wr, ctrl_rd, prdata, ctrl_addr, ctrl_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got rdy=%b err=%b wr=%b rd=%b prdata=%h addr=%h data=%h want all 0",
                     pready, pslverr, ctrl_wr, ctrl_rd, prdata, ctrl_addr, ctrl_data);
        end
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, err, waits, tout);
        apb_idle();
        n_cmp++;
        if (tout !== 1'b0 || err !== 1'b0 || waits != 1 || rd !== 32'h0000_001A) begin
            n_fail++;
            $display("FAIL post_reset_divisor: got tout=%b err=%b waits=%0d rdata=%h want 0/0/1/0000001a",
                     tout, err, waits, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rx();
        test_illegal();
        test_strobes();
        test_back_to_back();
        test_stray_penable();
        test_reset_mid_read();
        n_cmp++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes want 0", overlap);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
